// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
//   state_t   : serializer FSM states (IDLE: nothing in flight, SHIFT: word being sent)
//   first_bit : first bit to leave the serializer for a word of a given width/order
package piso_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // The word is passed zero-extended to 32 bits so one function serves every WIDTH.
    function automatic logic first_bit(input logic [31:0] word, input int unsigned width,
                                       input bit msb_first);
        logic [31:0] shifted;
        shifted = word >> (width - 1);
        return msb_first ? shifted[0] : word[0];
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer feeding a single-bit registered data path.
// A WIDTH-bit word is accepted over valid/ready and sent one bit per enabled clock.
// Ports:
//   clk         : clock, all state changes on the rising edge
//   rst         : synchronous active-high reset
//   in_data     : parallel word, sampled only at accept
//   in_valid    : in_data is valid
//   in_ready    : word can be accepted this cycle (combinational, independent of in_valid)
//   shift_en    : clock enable; low holds every register and blocks accepts
//   ser_out     : serial data bit (registered)
//   ser_valid   : ser_out carries a valid bit (registered)
//   frame_start : ser_out carries the first bit of a word (registered)
//   busy        : a word is in flight
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH);

    state_t            state;
    logic [WIDTH-1:0]  sreg;
    // Bits still to send after the one currently on ser_out.
    logic [CntW-1:0]   cnt;
    logic              accept;

    // Ready on the last bit of a word as well, so consecutive words need no idle cycle.
    assign in_ready = !rst && shift_en && (state == IDLE || (state == SHIFT && cnt == '0));
    assign accept   = in_valid && in_ready;
    assign busy     = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sreg        <= '0;
            cnt         <= '0;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else if (shift_en) begin
            if (accept) begin
                state       <= SHIFT;
                sreg        <= in_data;
                cnt         <= CntW'(WIDTH - 1);
                ser_out     <= first_bit(32'(in_data), WIDTH, MSB_FIRST);
                ser_valid   <= 1'b1;
                frame_start <= 1'b1;
            end else if (state == SHIFT) begin
                if (cnt != '0) begin
                    // sreg keeps the current bit at its exit end; the next bit sits beside it.
                    if (MSB_FIRST) begin
                        ser_out <= sreg[WIDTH-2];
                        sreg    <= {sreg[WIDTH-2:0], 1'b0};
                    end else begin
                        ser_out <= sreg[1];
                        sreg    <= {1'b0, sreg[WIDTH-1:1]};
                    end
                    cnt         <= cnt - 1'b1;
                    frame_start <= 1'b0;
                end else begin
                    state       <= IDLE;
                    sreg        <= '0;
                    ser_out     <= 1'b0;
                    ser_valid   <= 1'b0;
                    frame_start <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that feeds a single-bit registered data path, such as the din input of the flip-flop block.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per enabled clock on ser_out.
- Qualifies the output with ser_valid and a first-bit marker.
- Supports seamless back-to-back words with no idle bubble.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, synchronous, active-high
in_data  input  WIDTH  parallel word to serialize
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle (combinational)
shift_en  input  1  clock enable for shifting; low = hold all serial state
ser_out  output  1  serial data bit (registered)
ser_valid  output  1  ser_out holds a valid bit (registered)
frame_start  output  1  high while ser_out carries the first bit of a word (registered)
busy  output  1  a word is in flight (state == SHIFT)

Behaviour:
- Reset: rst sampled at posedge clk.
  - State becomes IDLE; shift register and bit counter clear.
  - ser_out = 0, ser_valid = 0, frame_start = 0, busy = 0.
  - in_ready is 0 while rst is high.
  - Reset mid-word abandons the word with no further bits; the word is not retried.
- States:
  - IDLE: no word in flight.
  - SHIFT: cnt holds the number of bits remaining after the current ser_out bit.
- in_ready is combinational and not dependent on in_valid:
  - in_ready = !rst && shift_en && (state == IDLE || (state == SHIFT && cnt == 0)).
- Accept occurs when in_valid && in_ready at posedge:
  - shift register loads in_data.
  - ser_out <= first bit (MSB or LSB per MSB_FIRST).
  - ser_valid <= 1, frame_start <= 1, cnt <= WIDTH-1, state <= SHIFT.
  - Latency: the first bit is visible in the cycle after the accept edge.
- SHIFT with shift_en = 1 and cnt > 0:
  - shift one position; ser_out <= next bit; frame_start <= 0; cnt <= cnt-1.
- SHIFT with shift_en = 1, cnt == 0, and no accept:
  - state <= IDLE; ser_valid <= 0; ser_out <= 0; frame_start <= 0.
- SHIFT with cnt == 0 and accept (back-to-back):
  - load the new word as in the accept rule; no gap cycle.
  - ser_valid stays 1; frame_start pulses again.
- shift_en = 0:
  - all registers hold, including ser_out, ser_valid, frame_start and cnt.
  - in_ready = 0.
  - No accept can occur while stalled.
- in_data is sampled only at accept; changes to in_data afterwards do not affect the word in flight.
- Each word occupies exactly WIDTH enabled cycles on ser_out, and ser_valid is high for all of them.
- cnt width is $clog2(WIDTH).
- No combinational path from in_valid to any output.

Decomposition:
- Package piso_pkg holds:
  - state_t enum {IDLE, SHIFT}
  - function first_bit(word, msb_first) used by both the RTL and the scoreboard model
- No sub-module: the shift register, counter and FSM sit in one always block plus the in_ready assign.
- The testbench interface mirrors the port list, with a clocking block sampling on posedge.

Test Plan (WIDTH=8 unless stated):
1. Reset then idle: rst = 1 for 2 cycles, then rst = 0 with in_valid = 0 → ser_out = 0, ser_valid = 0, busy = 0, in_ready = 1.
2. Single word, MSB_FIRST = 1: send 0xA5 → ser_out = 1,0,1,0,0,1,0,1 over 8 cycles; frame_start is high only on the first bit; ser_valid drops in cycle 9.
3. Back-to-back: 0xF0 followed immediately by 0x0F, with in_valid held → 16 consecutive valid bits 11110000 00001111; frame_start high in cycles 1 and 9; ser_valid never drops.
4. Stall: drop shift_en for 3 cycles after the 3rd bit of 0xC3 → ser_out and the count hold; stream resumes as 11000011 with 8 valid bits total; in_ready = 0 during the stall.
5. LSB-first build (MSB_FIRST = 0): send 0x01 → ser_out = 1 then 0 for seven bits.
6. Reset mid-word: assert rst after the 4th bit of 0xFF → next cycle ser_valid = 0 and ser_out = 0; a new word 0x80 afterwards serializes cleanly as 10000000.
